// File: rtl/aes128_pipe_encrypt.sv
// AES-128 encrypt core, fully pipelined: one block in and one block out per clock.
// Every beat carries its own key, and the round keys are expanded stage by stage
// alongside the data. There are 12 register stages and the latency is 11 edges.

// Forward S-box, implemented as a combinational table lookup.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    assign o_byte = SBOX[i_byte];
endmodule

// One step of the key schedule: the previous round key goes in, the next round key comes out.
module aes_key_exp (
    input  logic [127:0] i_key,
    input  logic [7:0]   i_rcon,
    output logic [127:0] o_key
);
    logic [31:0] w_rot, w_sub, w_tmp;
    logic [31:0] w_w0, w_w1, w_w2, w_w3;

    // RotWord: the top byte of the last word wraps around to the bottom.
    assign w_rot = {i_key[23:0], i_key[31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_sub
        aes_sbox u_sbox (.i_byte(w_rot[8*b +: 8]), .o_byte(w_sub[8*b +: 8]));
    end

    assign w_tmp = w_sub ^ {i_rcon, 24'h0};
    assign w_w0  = i_key[127:96] ^ w_tmp;
    assign w_w1  = i_key[95:64]  ^ w_w0;
    assign w_w2  = i_key[63:32]  ^ w_w1;
    assign w_w3  = i_key[31:0]   ^ w_w2;
    assign o_key = {w_w0, w_w1, w_w2, w_w3};
endmodule

// One cipher round. FINAL drops MixColumns, as the last round requires.
module aes_round #(
    parameter bit FINAL = 1'b0
) (
    input  logic [127:0] i_state,
    input  logic [127:0] i_rkey,
    output logic [127:0] o_state
);
    // Element 0 is byte 0, the most significant byte. Byte 4c+r is row r, column c.
    logic [0:15][7:0] w_in, w_sb, w_sr, w_mc;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    assign w_in = i_state;

    for (genvar b = 0; b < 16; b++) begin : g_sub
        aes_sbox u_sbox (.i_byte(w_in[b]), .o_byte(w_sb[b]));
    end

    // ShiftRows: row r rotates left by r columns.
    for (genvar c = 0; c < 4; c++) begin : g_shift
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign w_sr[4*c+r] = w_sb[4*((c+r)%4)+r];
        end
    end

    if (FINAL) begin : g_nomix
        assign w_mc = w_sr;
    end else begin : g_mix
        for (genvar c = 0; c < 4; c++) begin : g_col
            assign w_mc[4*c+0] = xt(w_sr[4*c]) ^ xt(w_sr[4*c+1]) ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ w_sr[4*c+3];
            assign w_mc[4*c+1] = w_sr[4*c] ^ xt(w_sr[4*c+1]) ^ xt(w_sr[4*c+2]) ^ w_sr[4*c+2] ^ w_sr[4*c+3];
            assign w_mc[4*c+2] = w_sr[4*c] ^ w_sr[4*c+1] ^ xt(w_sr[4*c+2]) ^ xt(w_sr[4*c+3]) ^ w_sr[4*c+3];
            assign w_mc[4*c+3] = xt(w_sr[4*c]) ^ w_sr[4*c] ^ w_sr[4*c+1] ^ w_sr[4*c+2] ^ xt(w_sr[4*c+3]);
        end
    end

    assign o_state = w_mc ^ i_rkey;
endmodule

module aes128_pipe_encrypt (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] data_in,
    input  logic [127:0] key,
    output logic [127:0] cryptokey
);
    localparam logic [0:9][7:0] RCON = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    // r_state[i] holds the state after round i, and r_rkey[i] holds round key i of
    // the same beat. Round key 10 is only used combinationally, so it has no register.
    logic [127:0] r_state [0:10];
    logic [127:0] r_rkey  [0:9];
    logic [127:0] w_state [1:10];
    logic [127:0] w_rkey  [1:10];

    for (genvar g = 1; g <= 10; g++) begin : g_stage
        aes_key_exp u_kexp (
            .i_key  (r_rkey[g-1]),
            .i_rcon (RCON[g-1]),
            .o_key  (w_rkey[g])
        );
        aes_round #(.FINAL(g == 10)) u_round (
            .i_state (r_state[g-1]),
            .i_rkey  (w_rkey[g]),
            .o_state (w_state[g])
        );
    end

    // Pipeline advance: there is no stall, and every stage (including the output) clears on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= 10; i++) r_state[i] <= '0;
            for (int i = 0; i <= 9; i++)  r_rkey[i]  <= '0;
            cryptokey <= '0;
        end else begin
            r_state[0] <= data_in ^ key;
            r_rkey[0]  <= key;
            for (int i = 1; i <= 10; i++) r_state[i] <= w_state[i];
            for (int i = 1; i <= 9; i++)  r_rkey[i]  <= w_rkey[i];
            cryptokey <= r_state[10];
        end
    end
endmodule

// File: tb/tb_aes128_pipe_encrypt.sv
// Bench for aes128_pipe_encrypt. Each driven beat pushes its expected ciphertext
// and the edge at which it is due. A monitor pops the entry and compares it on the falling edge.
module tb_aes128_pipe_encrypt;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2  = 128'h0f1571c947d9e8590cb7add6af7f6798;
    localparam logic [127:0] P2  = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [127:0] C2  = 128'hff0b844a0853bf7c6934ab4364148fb9;
    localparam logic [127:0] CZ  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [127:0] data_in = '0;
    logic [127:0] key = '0;
    logic [127:0] cryptokey;

    typedef struct {
        int           due;
        logic [127:0] exp;
    } exp_t;

    exp_t sb[$];
    int   edges = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    aes128_pipe_encrypt dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .key       (key),
        .cryptokey (cryptokey)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edges);
        end
    endtask

    // Scoreboard side: a beat captured at edge N is due right after edge N+11.
    always @(negedge clk) begin
        if (reset && sb.size() > 0 && sb[0].due == edges) begin
            chk("ct", cryptokey, sb[0].exp);
            void'(sb.pop_front());
        end
    end

    task automatic drive(input logic [127:0] d, input logic [127:0] k, input logic [127:0] e);
        data_in = d;
        key     = k;
        sb.push_back('{due: edges + 1 + 11, exp: e});
    endtask

    // Hold one vector for n beats. The result must not appear on the edge before it is due.
    task automatic stream(input string tag, input int n, input logic [127:0] d,
                          input logic [127:0] k, input logic [127:0] e);
        int first_cap;
        first_cap = edges + 1;
        for (int i = 0; i < n; i++) begin
            drive(d, k, e);
            @(posedge clk);
            #1;
            if (edges == first_cap + 10)
                chk(tag, {127'b0, cryptokey == e}, 128'h0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
        #1;
        chk("drain_empty", 128'(sb.size()), 128'h0);
    endtask

    initial begin
        // Asynchronous reset with arbitrary inputs: the output clears before any clock edge.
        data_in = {$urandom, $urandom, $urandom, $urandom};
        key     = {$urandom, $urandom, $urandom, $urandom};
        #2 reset = 1'b0;
        #1 chk("rst_async", cryptokey, 128'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 chk("rst_hold", cryptokey, 128'h0);
        end
        @(negedge clk);
        reset = 1'b1;

        // Known-answer vectors, each held constant.
        stream("v1_not_early", 14, P1, K1, C1);
        stream("v2_not_early", 14, P2, K2, C2);

        // Different keys on alternate beats: the output must stay in order with no bubbles.
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) drive(P2, K2, C2);
            else            drive(P1, K1, C1);
            @(posedge clk);
            #1;
        end

        stream("zero_not_early", 13, 128'h0, 128'h0, CZ);
        drain();

        // Mid-stream reset pulse between edges: the output clears at once and in-flight beats are lost.
        stream("v2_pre_rst", 5, P2, K2, C2);
        #1 reset = 1'b0;
        #1 chk("rst_mid", cryptokey, 128'h0);
        sb.delete();
        #1 chk("rst_mid_hold", cryptokey, 128'h0);
        reset = 1'b1;
        stream("v2_post_rst_not_early", 13, P2, K2, C2);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/aes128_pipe_encrypt.md
Name: aes128_pipe_encrypt

Overview:
Fully pipelined AES-128 encryption core (FIPS-197, encrypt only). It accepts a new 128-bit plaintext/key pair on every clock and delivers one 128-bit ciphertext per clock after a fixed latency. The key schedule is pipelined alongside the data, so every beat may carry a different key. It sits between a block-data source and a consumer; there is no handshake.

Parameters:
None. Key size is fixed at 128 bits and the round count at 10.

Ports:
clk  input  1  rising-edge clock; the only clock.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
data_in  input  128  plaintext block; bits [127:120] = byte 0 (FIPS-197 byte order, big-endian).
key  input  128  cipher key for this beat; same byte order as data_in.
cryptokey  output  128  ciphertext block; same byte order; registered.

Behaviour:
- Reset: while reset=0, all pipeline state, round-key registers and cryptokey clear to 128'h0 immediately, without waiting for a clock edge. Registers stay cleared until reset=1; capture resumes on the first rising edge with reset=1.
- Pipeline: 12 register stages, one beat per stage, advancing on every rising edge with no stall or enable.
  - Stage 0: captures data_in XOR key (initial AddRoundKey) and captures key.
  - Stages 1-9: each performs one full round (SubBytes, ShiftRows, MixColumns, AddRoundKey) using round key k1..k9.
  - Stage 10: performs the final round (SubBytes, ShiftRows, AddRoundKey with k10; no MixColumns).
  - Stage 11: cryptokey output register.
- Key schedule: each stage derives the next round key from its registered previous round key (RotWord, SubWord, Rcon XOR; Rcon = 01,02,04,08,10,20,40,80,1b,36). The round key travels with its data beat. The key schedule holds no state shared between beats.
- Latency: a pair sampled at rising edge N appears on cryptokey immediately after edge N+11. The value stays valid until edge N+12.
- Throughput: one result per clock. Back-to-back beats with different keys must not interfere.
- Fill: after reset release, cryptokey shows the pipelined result of whatever was on the inputs at each edge. No valid flag is provided, so the consumer counts 11 cycles.
- Reset mid-stream: all in-flight beats are discarded and cryptokey reads 0 at once. The first post-reset beat emerges 11 edges after its capture.
- S-box: standard AES forward S-box, combinational, 16 instances per round stage plus 4 per key-expansion stage.
- MixColumns: GF(2^8) arithmetic, polynomial x^8+x^4+x^3+x+1 (xtime reduction 8'h1b).

Test Plan:
1. Reset check: drive reset=0 with arbitrary inputs -> cryptokey=128'h0 immediately, with no clock edge needed, and for as long as reset stays 0.
2. FIPS-197 vector: key=000102030405060708090a0b0c0d0e0f, data_in=00112233445566778899aabbccddeeff, held constant -> cryptokey=69c4e0d86a7b0430d8cdb78070b4c55a exactly 11 edges after the first capture edge, and not earlier.
3. Second vector: key=0f1571c947d9e8590cb7add6af7f6798, data_in=0123456789abcdeffedcba9876543210 -> cryptokey=ff0b844a0853bf7c6934ab4364148fb9 after 11 edges.
4. Throughput: alternate vectors 2 and 3 every clock for 12 beats -> starting 11 edges after the first capture, cryptokey alternates ff0b844a0853bf7c6934ab4364148fb9 / 69c4e0d86a7b0430d8cdb78070b4c55a on every clock, in input order, with no bubbles.
5. All-zero vector: key=0, data_in=0 -> cryptokey=66e94bd4ef8a2c3b884cfa59ca342b2e after 11 edges.
6. Mid-stream reset: stream vector 2 for 5 cycles, then pulse reset=0 between edges -> cryptokey=0 at once. After release and a restart of the stream, the first correct result appears 11 edges after the first post-reset capture.
